// File: rtl/seg_pkg.sv
// seg_pkg: shared scan FSM state type and active-low {a..g} pattern table indexed by hex value
package seg_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_LIT} state_t;
  localparam logic [15:0][6:0] SEG_TBL = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex decode (i_nib 4-bit in, o_seg_n 7-bit active-low {a..g} out)
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);
  assign o_seg_n = SEG_TBL[i_nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-seg scanner (clk, rst_n, enable, load_valid/data/blank in; load_ready, seg_n, an_n, frame_done out)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int DEAD_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);
  localparam int MAXC = DWELL_CYCLES > DEAD_CYCLES ? DWELL_CYCLES : DEAD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  state_t                  r_state, w_state_nx;
  logic [IW-1:0]           r_idx, w_idx_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [4*NUM_DIGITS-1:0] r_data, r_pdata, w_data_nx;
  logic [NUM_DIGITS-1:0]   r_blank, r_pblank, w_blank_nx, w_an_nx, r_an_n;
  logic                    r_full, r_ready, w_accept, w_xfer, w_boundary, w_full_nx;
  logic [3:0]              w_nib;
  logic [6:0]              w_dec, r_seg_n;

  assign w_boundary = enable && r_state == ST_LIT && r_idx == IDX_LAST && r_cnt == DWELL_LAST;
  assign w_accept   = load_valid && r_ready;
  assign w_xfer     = r_full && (w_boundary || r_state == ST_OFF);
  assign w_full_nx  = w_accept || (r_full && !w_xfer);
  assign w_data_nx  = w_xfer ? r_pdata : r_data;
  assign w_blank_nx = w_xfer ? r_pblank : r_blank;
  assign frame_done = w_boundary;
  assign load_ready = r_ready;
  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_blank  <= '1;
      r_pdata  <= '0;
      r_pblank <= '1;
      r_full   <= 1'b0;
      r_ready  <= 1'b0;
      r_seg_n  <= '1;
      r_an_n   <= '1;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_data  <= w_data_nx;
      r_blank <= w_blank_nx;
      if (w_accept) begin
        r_pdata  <= load_data;
        r_pblank <= load_blank;
      end
      r_full  <= w_full_nx;
      r_ready <= !w_full_nx;
      r_seg_n <= w_state_nx == ST_LIT ? w_dec : '1;
      r_an_n  <= w_an_nx;
    end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt + CW'(1);
    if (!enable) begin
      w_state_nx = ST_OFF;
      w_idx_nx   = '0;
      w_cnt_nx   = '0;
    end else if (r_state == ST_OFF) begin
      w_state_nx = ST_DEAD;
      w_idx_nx   = '0;
      w_cnt_nx   = '0;
    end else if (r_state == ST_DEAD && r_cnt == DEAD_LAST) begin
      w_state_nx = ST_LIT;
      w_cnt_nx   = '0;
    end else if (r_state == ST_LIT && r_cnt == DWELL_LAST) begin
      w_state_nx = ST_DEAD;
      w_cnt_nx   = '0;
      w_idx_nx   = r_idx == IDX_LAST ? '0 : r_idx + IW'(1);
    end
  end

  // outputs are computed from next-state values so the registered pins line up with the state register
  always_comb begin
    w_nib   = '0;
    w_an_nx = '1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (IW'(k) == w_idx_nx) begin
        w_nib      = w_data_nx[4*k +: 4];
        w_an_nx[k] = !(w_state_nx == ST_LIT && !w_blank_nx[k]);
      end
  end

  hex_to_seg u_dec (.i_nib(w_nib), .o_seg_n(w_dec));
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl with 4 digits, dwell 4, dead 2
module tb_seg_scan_ctrl;
  logic        clk = 0, rst_n = 1, enable = 0, load_valid = 0;
  logic        load_ready, frame_done;
  logic [15:0] load_data = '0;
  logic [3:0]  load_blank = '0, an_n;
  logic [6:0]  seg_n;
  int          errors = 0, checks = 0;
  logic [6:0]  seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_blank(load_blank), .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  task automatic scan_frame(input string nm, input logic [15:0] d, input logic [3:0] b, input logic rdy0,
                            input logic rdy, input int act_t, input logic act_v, input logic [15:0] act_d,
                            input int nt);
    for (int t = 0; t < nt; t++) begin
      int k;
      logic lit, ef, er;
      logic [3:0] nib, ea;
      logic [6:0] es;
      @(posedge clk);
      #1;
      k   = t / 6;
      lit = (t % 6) >= 2;
      nib = d[4*k +: 4];
      ea  = (lit && !b[k]) ? ~(4'b0001 << k) : 4'hF;
      es  = lit ? seg_tbl[nib] : 7'h7F;
      ef  = (t == 23);
      er  = (t == 0) ? rdy0 : rdy;
      checks++;
      if (an_n !== ea) begin
        errors++;
        $display("FAIL %s an_n t=%0d got %b exp %b", nm, t, an_n, ea);
      end
      checks++;
      if (seg_n !== es) begin
        errors++;
        $display("FAIL %s seg_n t=%0d got %b exp %b", nm, t, seg_n, es);
      end
      checks++;
      if (frame_done !== ef) begin
        errors++;
        $display("FAIL %s frame_done t=%0d got %b exp %b", nm, t, frame_done, ef);
      end
      checks++;
      if (load_ready !== er) begin
        errors++;
        $display("FAIL %s load_ready t=%0d got %b exp %b", nm, t, load_ready, er);
      end
      if (t == act_t) begin
        load_valid = act_v;
        load_data  = act_d;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an_n !== 4'hF) begin errors++; $display("FAIL reset an_n got %b exp 1111", an_n); end
    checks++;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset seg_n got %b exp 1111111", seg_n); end
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL reset load_ready got %b exp 0", load_ready); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
    rst_n = 1;
    @(posedge clk);
    #1;
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_release load_ready got %b exp 1", load_ready); end
    checks++;
    if (an_n !== 4'hF) begin errors++; $display("FAIL reset_release an_n got %b exp 1111", an_n); end
  endtask

  task automatic test_blank_scan();
    enable = 1;
    scan_frame("blank_f1", 16'h0000, 4'hF, 1, 1, -1, 0, 16'h0000, 24);
    scan_frame("blank_f2", 16'h0000, 4'hF, 1, 1, -1, 0, 16'h0000, 24);
  endtask

  task automatic test_load();
    load_data = 16'h1A3F; load_blank = 4'h0; load_valid = 1;
    scan_frame("load_wait", 16'h0000, 4'hF, 0, 0, 0, 0, 16'h1A3F, 24);
    scan_frame("load_show", 16'h1A3F, 4'h0, 1, 1, -1, 0, 16'h1A3F, 24);
  endtask

  task automatic test_back_to_back();
    load_data = 16'h1111; load_valid = 1;
    scan_frame("b2b_1", 16'h1A3F, 4'h0, 0, 0, 0, 1, 16'h2222, 24);
    scan_frame("b2b_2", 16'h1111, 4'h0, 1, 0, 1, 0, 16'h2222, 24);
    scan_frame("b2b_3", 16'h2222, 4'h0, 1, 1, -1, 0, 16'h2222, 24);
  endtask

  task automatic test_enable_drop();
    scan_frame("drop_pre", 16'h2222, 4'h0, 1, 1, -1, 0, 16'h2222, 16);
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (an_n !== 4'hF) begin errors++; $display("FAIL drop_off an_n c=%0d got %b exp 1111", i, an_n); end
      checks++;
      if (seg_n !== 7'h7F) begin errors++; $display("FAIL drop_off seg_n c=%0d got %b exp 1111111", i, seg_n); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL drop_off frame_done c=%0d got %b exp 0", i, frame_done); end
    end
    enable = 1;
    scan_frame("drop_restart", 16'h2222, 4'h0, 1, 1, -1, 0, 16'h2222, 24);
  endtask

  task automatic test_blank_mask();
    load_data = 16'h1A3F; load_blank = 4'b0101; load_valid = 1;
    scan_frame("mask_wait", 16'h2222, 4'h0, 0, 0, 0, 0, 16'h1A3F, 24);
    scan_frame("mask_show", 16'h1A3F, 4'b0101, 1, 1, -1, 0, 16'h1A3F, 24);
  endtask

  task automatic test_async_reset();
    load_data = 16'h2222; load_blank = 4'h0; load_valid = 1;
    scan_frame("arst_pre", 16'h1A3F, 4'b0101, 0, 0, 0, 0, 16'h2222, 10);
    #2 rst_n = 0;
    #1;
    checks++;
    if (an_n !== 4'hF) begin errors++; $display("FAIL arst an_n got %b exp 1111", an_n); end
    checks++;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL arst seg_n got %b exp 1111111", seg_n); end
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL arst load_ready got %b exp 0", load_ready); end
    rst_n = 1;
    scan_frame("arst_post1", 16'h0000, 4'hF, 1, 1, -1, 0, 16'h2222, 24);
    scan_frame("arst_post2", 16'h0000, 4'hF, 1, 1, -1, 0, 16'h2222, 24);
  endtask

  task automatic test_off_load();
    enable = 0; load_data = 16'h05C8; load_blank = 4'h0; load_valid = 1;
    @(posedge clk);
    #1;
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL off_load accept load_ready got %b exp 0", load_ready); end
    checks++;
    if (an_n !== 4'hF) begin errors++; $display("FAIL off_load an_n got %b exp 1111", an_n); end
    load_valid = 0;
    @(posedge clk);
    #1;
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL off_load xfer load_ready got %b exp 1", load_ready); end
    enable = 1;
    scan_frame("off_load_show", 16'h05C8, 4'h0, 1, 1, -1, 0, 16'h05C8, 24);
  endtask

  initial begin
    test_reset();
    test_blank_scan();
    test_load();
    test_back_to_back();
    test_enable_drop();
    test_blank_mask();
    test_async_reset();
    test_off_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
